// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of digit slices needed to cover the operand width.
  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 1 : width / digit;
  endfunction

  // Counter must hold 0..n without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit combinational adder slice with carry in/out.
module adder_slice #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    s    = full[DIGIT-1:0];
    cout = full[DIGIT];
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial adder: one shared adder slice sequenced over WIDTH/DIGIT cycles,
// with valid/ready handshakes on both the operand and the result side.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int unsigned     N       = num_digits(WIDTH, DIGIT);
  localparam int unsigned     CntW    = cnt_width(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_bad_params
    $error("serial_adder_ctrl: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_shift;

  adder_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  // New digit enters at the top; after N steps digit 0 has reached bit 0.
  always_comb begin
    sum_shift = WIDTH'({slice_s, sum[WIDTH-1:0]} >> DIGIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q            <= a_q >> DIGIT;
          b_q            <= b_q >> DIGIT;
          carry_q        <= slice_cout;
          cnt_q          <= cnt_q + CntW'(1);
          sum[WIDTH-1:0] <= sum_shift;
          if (cnt_q == LastCnt) begin
            sum[WIDTH] <= slice_cout;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          // in_ready rises with the return to idle, so no same-cycle accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a cycle-level model.
module tb_serial_adder_ctrl;

  localparam int W = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W:0]   sum;

  logic         iv8 = 1'b0;
  logic         or8 = 1'b1;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         r82, v82, bz82, r81, v81, bz81;
  logic [8:0]   s82, s81;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(4), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(8), .DIGIT(2)) dut82 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(r82), .a(a8), .b(b8),
    .out_valid(v82), .out_ready(or8), .sum(s82), .busy(bz82)
  );

  serial_adder_ctrl #(.WIDTH(8), .DIGIT(1)) dut81 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(r81), .a(a8), .b(b8),
    .out_valid(v81), .out_ready(or8), .sum(s81), .busy(bz81)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted pair is busy for N cycles, then held as a+b until taken.
  logic       m_ready = 1'b0;
  logic       m_valid = 1'b0;
  int         m_wait = 0;
  logic [W:0] m_pend = '0;
  logic [W:0] m_sum = '0;
  int         m_acc = 0;
  int         dut_hs = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_sum   <= '0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_wait > 0) begin
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_sum   <= m_pend;
      end
      m_wait <= m_wait - 1;
    end else if (m_ready && in_valid) begin
      m_pend  <= {1'b0, a} + {1'b0, b};
      m_wait  <= N;
      m_ready <= 1'b0;
      m_acc   <= m_acc + 1;
    end else begin
      m_ready <= 1'b1;
    end
    if (rst_n && out_valid === 1'b1 && out_ready) dut_hs <= dut_hs + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(m_wait != 0));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_wait == 0) chk("sum", 64'(sum), 64'(m_sum));
    end
  end

  task automatic wait_ready(input string name);
    int i;
    i = 0;
    while (in_ready !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (in_ready !== 1'b1) chk({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int c2, c1, base_acc, base_hs, cyc;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 8-bit instances: FF+FF with DIGIT=2 (4 cycles) and DIGIT=1 (8 cycles).
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    c2 = -1; c1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (v82 === 1'b1 && c2 < 0) begin c2 = k; chk("w8d2_sum", 64'(s82), 64'h1FE); end
      if (v81 === 1'b1 && c1 < 0) begin c1 = k; chk("w8d1_sum", 64'(s81), 64'h1FE); end
    end
    chk("w8d2_latency", 64'(c2), 64'd4);
    chk("w8d1_latency", 64'(c1), 64'd8);

    // F + 1 with immediate acceptance of the result.
    wait_ready("t1");
    a = 4'hF; b = 4'h1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_sum", 64'(sum), 64'h10);
    @(negedge clk);
    chk("t1_ready_after", 64'(in_ready), 64'd1);
    chk("t1_valid_drop", 64'(out_valid), 64'd0);

    // 5 + A under backpressure.
    out_ready = 1'b0;
    a = 4'h5; b = 4'hA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_sum", 64'(sum), 64'h0F);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", 64'(out_valid), 64'd0);

    // Operands changing during RUN must not leak in.
    wait_ready("t4");
    out_ready = 1'b0;
    a = 4'h3; b = 4'h4; in_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("t4_ready_low", 64'(in_ready), 64'd0);
      a = 4'($urandom);
      @(negedge clk);
    end
    chk("t4_sum", 64'(sum), 64'h07);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset at the first digit edge, then a clean 8 + 8.
    wait_ready("t5");
    out_ready = 1'b1;
    a = 4'hF; b = 4'hF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_sum", 64'(sum), 64'd0);
    wait_ready("t5b");
    a = 4'h8; b = 4'h8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_valid2", 64'(out_valid), 64'd1);
    chk("t5_sum2", 64'(sum), 64'h10);
    @(negedge clk);

    // Random traffic with random stalls.
    base_acc = m_acc;
    base_hs  = dut_hs;
    cyc = 0;
    while (m_acc - base_acc < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 4'($urandom);
      b         = 4'($urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((m_valid || m_wait != 0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("rand_accepts", 64'(m_acc - base_acc), 64'd1000);
    chk("rand_handshakes", 64'(dut_hs - base_hs), 64'(m_acc - base_acc));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
